// File: rtl/regbank_pkg.sv
// Shared constants and FSM state type for the
// register bank write port.
package regbank_pkg;

   localparam int ENTRIES = 16;
   localparam int ADDR_W  = 4;

   localparam logic [ADDR_W-1:0] ZERO_IDX = 4'd15;
   localparam logic [ADDR_W-1:0] LAST_IDX = 4'(ENTRIES - 1);

   typedef enum logic [1:0] {
      IDLE,
      CLEAR,
      DONE
   } state_t;

endpackage

// File: rtl/decoder4_16.sv
// One-hot 4:16 decoder with enable; write-side dual
// of the 16:1 read select tree.
module decoder4_16
   import regbank_pkg::*;
(
   input  logic              en,
   input  logic [ADDR_W-1:0] in,
   output logic [ENTRIES-1:0] out
);

   always_comb begin
      out = '0;
      if (en) out[in] = 1'b1;
   end

endmodule

// File: rtl/demux16_reg_writer.sv
// Register file write port: staged write, one-hot
// commit into 16 entries, sequenced bank clear.
module demux16_reg_writer
   import regbank_pkg::*;
#(
   parameter int WIDTH     = 64,
   parameter int ZERO_LAST = 1
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic                     wr_valid,
   output logic                     wr_ready,
   input  logic [ADDR_W-1:0]        wr_addr,
   input  logic [WIDTH-1:0]         wr_data,
   input  logic                     clr_req,
   output logic                     busy,
   output logic                     clr_done,
   output logic                     wr_drop,
   output logic [ENTRIES*WIDTH-1:0] q,
   output logic [ENTRIES-1:0]       q_valid
);

   localparam logic [ENTRIES-1:0] ONE = 1;
   localparam logic [ENTRIES-1:0] WMASK =
      (ZERO_LAST != 0) ? ~(ONE << ZERO_IDX) : '1;

   state_t              r_state;
   state_t              w_nxt;
   logic [ADDR_W-1:0]   r_cnt;

   logic                r_stg_vld;
   logic [ADDR_W-1:0]   r_stg_addr;
   logic [WIDTH-1:0]    r_stg_data;

   logic [WIDTH-1:0]    r_bank [ENTRIES];
   logic [ENTRIES-1:0]  r_vld;
   logic                r_drop;

   logic                w_accept;
   logic                w_commit;
   logic                w_clr;
   logic [ENTRIES-1:0]  w_wen;
   logic [ENTRIES-1:0]  w_cen;

   always_comb begin
      w_nxt    = r_state;
      wr_ready = 1'b0;
      busy     = 1'b0;
      clr_done = 1'b0;
      unique case (r_state)
         IDLE: begin
            wr_ready = 1'b1;
            if (clr_req) w_nxt = CLEAR;
         end
         CLEAR: begin
            busy = 1'b1;
            if (r_cnt == LAST_IDX) w_nxt = DONE;
         end
         DONE: begin
            clr_done = 1'b1;
            w_nxt    = IDLE;
         end
         default: w_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= IDLE;
         r_cnt   <= '0;
      end else begin
         r_state <= w_nxt;
         if (r_state == CLEAR) r_cnt <= r_cnt + 4'd1;
      end
   end

   assign w_accept = wr_valid & wr_ready;
   // A write staged on the clear-request edge is never
   // committed: commit only happens while IDLE.
   assign w_commit = r_stg_vld & (r_state == IDLE);
   assign w_clr    = (r_state == CLEAR);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_stg_vld  <= 1'b0;
         r_stg_addr <= '0;
         r_stg_data <= '0;
      end else begin
         r_stg_vld <= w_accept;
         if (w_accept) begin
            r_stg_addr <= wr_addr;
            r_stg_data <= wr_data;
         end
      end
   end

   decoder4_16 u_wdec (
      .en  (w_commit),
      .in  (r_stg_addr),
      .out (w_wen)
   );

   decoder4_16 u_cdec (
      .en  (w_clr),
      .in  (r_cnt),
      .out (w_cen)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < ENTRIES; i++)
            r_bank[i] <= '0;
         r_vld <= '0;
      end else begin
         for (int i = 0; i < ENTRIES; i++) begin
            if (w_cen[i]) begin
               r_bank[i] <= '0;
               r_vld[i]  <= 1'b0;
            end else if (w_wen[i] && WMASK[i]) begin
               r_bank[i] <= r_stg_data;
               r_vld[i]  <= 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) r_drop <= 1'b0;
      else r_drop <= w_commit
                  && (r_stg_addr == ZERO_IDX)
                  && (ZERO_LAST != 0);
   end

   always_comb begin
      q = '0;
      for (int i = 0; i < ENTRIES; i++)
         q[i*WIDTH +: WIDTH] = r_bank[i];
   end

   assign q_valid = r_vld;
   assign wr_drop = r_drop;

endmodule

// File: tb/tb_demux16_reg_writer.sv
// Self-checking bench: per-cycle model compare plus
// directed literal checks for demux16_reg_writer.
module tb_demux16_reg_writer;

   localparam int W  = 64;
   localparam int QW = 16 * W;

   logic          clk = 1'b0;
   logic          reset_n;
   logic          wr_valid;
   logic          wr_ready;
   logic [3:0]    wr_addr;
   logic [W-1:0]  wr_data;
   logic          clr_req;
   logic          busy;
   logic          clr_done;
   logic          wr_drop;
   logic [QW-1:0] q;
   logic [15:0]   q_valid;

   int n_checks = 0;
   int n_pass   = 0;

   demux16_reg_writer #(.WIDTH(W), .ZERO_LAST(1)) dut (
      .clk      (clk),
      .reset_n  (reset_n),
      .wr_valid (wr_valid),
      .wr_ready (wr_ready),
      .wr_addr  (wr_addr),
      .wr_data  (wr_data),
      .clr_req  (clr_req),
      .busy     (busy),
      .clr_done (clr_done),
      .wr_drop  (wr_drop),
      .q        (q),
      .q_valid  (q_valid)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm,
                      input logic [QW-1:0] act,
                      input logic [QW-1:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h want %0h",
                    nm, act, exp);
   endtask

   function automatic logic [W-1:0] qe(input int i);
      return q[i*W +: W];
   endfunction

   // Model: sweep = -1 idle, 0..15 index being cleared,
   // 16 = done pulse. Pending = write awaiting commit.
   logic [W-1:0] m_q [16];
   bit           m_v [16];
   int           m_sweep;
   bit           m_pend;
   int           m_pa;
   logic [W-1:0] m_pd;
   bit           m_drop;

   task automatic m_reset();
      for (int i = 0; i < 16; i++) begin
         m_q[i] = '0;
         m_v[i] = 1'b0;
      end
      m_sweep = -1;
      m_pend  = 1'b0;
      m_pa    = 0;
      m_pd    = '0;
      m_drop  = 1'b0;
   endtask

   always @(posedge clk) begin
      if (reset_n) begin
         bit acc;
         int s;
         s   = m_sweep;
         acc = wr_valid && (s < 0);
         m_drop = 1'b0;
         if (m_pend && s < 0) begin
            if (m_pa == 15) m_drop = 1'b1;
            else begin
               m_q[m_pa] = m_pd;
               m_v[m_pa] = 1'b1;
            end
         end
         if (s >= 0 && s < 16) begin
            m_q[s]  = '0;
            m_v[s]  = 1'b0;
            m_sweep = s + 1;
         end else if (s == 16) m_sweep = -1;
         else if (clr_req) m_sweep = 0;
         m_pend = acc;
         m_pa   = int'(wr_addr);
         m_pd   = wr_data;
      end
   end

   always @(negedge clk) begin
      logic [QW-1:0] eq;
      logic [15:0]   ev;
      if (!reset_n) m_reset();
      eq = '0;
      ev = '0;
      for (int i = 0; i < 16; i++) begin
         eq[i*W +: W] = m_q[i];
         ev[i]        = m_v[i];
      end
      chk("m_q", q, eq);
      chk("m_q_valid", QW'(q_valid), QW'(ev));
      chk("m_wr_ready", QW'(wr_ready), QW'(m_sweep < 0));
      chk("m_busy", QW'(busy),
          QW'(m_sweep >= 0 && m_sweep < 16));
      chk("m_clr_done", QW'(clr_done),
          QW'(m_sweep == 16));
      chk("m_wr_drop", QW'(wr_drop), QW'(m_drop));
   end

   task automatic step(input bit v,
                       input logic [3:0] a,
                       input logic [W-1:0] d,
                       input bit c);
      wr_valid = v;
      wr_addr  = a;
      wr_data  = d;
      clr_req  = c;
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      step(1'b0, 4'd0, '0, 1'b0);
   endtask

   initial begin
      m_reset();
      reset_n  = 1'b0;
      wr_valid = 1'b0;
      wr_addr  = '0;
      wr_data  = '0;
      clr_req  = 1'b0;
      #3;
      chk("rst_q", q, '0);
      chk("rst_qv", QW'(q_valid), '0);
      chk("rst_busy", QW'(busy), '0);
      #9 reset_n = 1'b1;
      chk("rst_ready", QW'(wr_ready), QW'(1));

      // single write, one-edge commit latency
      step(1'b1, 4'd3, 64'hDEAD_BEEF, 1'b0);
      chk("lat_qv", QW'(q_valid), '0);
      idle();
      chk("w3_q", QW'(qe(3)), QW'(64'hDEAD_BEEF));
      chk("w3_qv", QW'(q_valid), QW'(16'h0008));

      // streaming writes 0..14
      for (int a = 0; a < 15; a++) begin
         step(1'b1, 4'(a), W'(a + 1), 1'b0);
         chk("stream_ready", QW'(wr_ready), QW'(1));
      end
      idle();
      chk("stream_qv", QW'(q_valid), QW'(16'h7FFF));
      chk("stream_q14", QW'(qe(14)), QW'(15));
      chk("stream_q3", QW'(qe(3)), QW'(4));

      // hardwired zero entry
      step(1'b1, 4'd15, '1, 1'b0);
      idle();
      chk("drop_pulse", QW'(wr_drop), QW'(1));
      idle();
      chk("drop_end", QW'(wr_drop), '0);
      chk("drop_q15", QW'(qe(15)), '0);
      chk("drop_qv", QW'(q_valid), QW'(16'h7FFF));

      // clear with colliding write to 5
      step(1'b1, 4'd5, 64'hAA, 1'b1);
      for (int i = 1; i <= 16; i++) begin
         chk("clr_busy", QW'(busy), QW'(1));
         chk("clr_ready", QW'(wr_ready), '0);
         step(1'b1, 4'd6, 64'h66, 1'b0);
         chk("clr_order", QW'(q_valid),
             QW'(16'h7FFF & (16'hFFFF << i)));
      end
      chk("done_pulse", QW'(clr_done), QW'(1));
      chk("done_busy", QW'(busy), '0);
      chk("done_ready", QW'(wr_ready), '0);
      chk("done_q", q, '0);
      step(1'b0, 4'd0, '0, 1'b1);
      chk("post_ready", QW'(wr_ready), QW'(1));
      chk("post_done", QW'(clr_done), '0);
      idle();
      chk("clr_ignored", QW'(busy), '0);

      // reset mid-sweep at counter 7
      step(1'b1, 4'd1, 64'h1, 1'b0);
      step(1'b1, 4'd10, 64'hA, 1'b0);
      step(1'b0, 4'd0, '0, 1'b1);
      for (int i = 0; i < 7; i++) idle();
      chk("mid_busy", QW'(busy), QW'(1));
      chk("mid_q10", QW'(qe(10)), QW'(64'hA));
      reset_n = 1'b0;
      #1;
      chk("arst_q", q, '0);
      chk("arst_qv", QW'(q_valid), '0);
      chk("arst_busy", QW'(busy), '0);
      @(posedge clk);
      #1 reset_n = 1'b1;
      step(1'b1, 4'd9, 64'h99, 1'b0);
      idle();
      chk("w9_q", QW'(qe(9)), QW'(64'h99));
      chk("w9_qv", QW'(q_valid), QW'(16'h0200));

      // write-after-write to entry 2
      step(1'b1, 4'd2, 64'h11, 1'b0);
      step(1'b1, 4'd2, 64'h22, 1'b0);
      chk("waw_first", QW'(qe(2)), QW'(64'h11));
      idle();
      chk("waw_second", QW'(qe(2)), QW'(64'h22));
      idle();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
